// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//
// This block sits between the peripheral interrupt lines and the CPU control
// FSM. Each request line passes through a 2-flop synchroniser and a
// rising-edge detector, and the result is latched into a pending register.
// A software mask is applied to the pending register. The block presents one
// fixed-priority source ID and holds it until the CPU acknowledges it
// (ack = save_state) and then ends the interrupt (eoi = restore_state).
// The lowest source index has the highest priority.
//
// Build option:
//   IRQ_LEVEL_SENSE_EN - adds a MODE register. A MODE bit of 1 makes that
//                        source level-sensitive. When the macro is undefined,
//                        every source is edge-sensitive and MODE reads as 0.
//
// Parameters:
//   NUM_SOURCES     - number of request inputs, must be <= 2**INTERRUPT_WIDTH-1
//   INTERRUPT_WIDTH - width of the ID bus; ID 0 = none, ID k = source k-1
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset; release is synchronised
//                   upstream
//   irq_in     in   raw request lines, asynchronous to clk
//   ack        in   one-cycle strobe, CPU accepted the presented ID
//   eoi        in   one-cycle strobe, handler finished
//   cfg_we     in   configuration write strobe
//   cfg_sel    in   0=MASK, 1=PEND (write-1-to-clear), 2=MODE, 3=reserved
//   cfg_wdata  in   configuration write data
//   cfg_rdata  out  combinational read of the selected register
//   interrupt  out  registered source ID, 0 = none
//   in_service out  high while a handler is active
// ---------------------------------------------------------------------------
module irq_controller #(
    parameter int NUM_SOURCES     = 8,
    parameter int INTERRUPT_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SOURCES-1:0]     irq_in,
    input  logic                       ack,
    input  logic                       eoi,
    input  logic                       cfg_we,
    input  logic [1:0]                 cfg_sel,
    input  logic [NUM_SOURCES-1:0]     cfg_wdata,
    output logic [NUM_SOURCES-1:0]     cfg_rdata,
    output logic [INTERRUPT_WIDTH-1:0] interrupt,
    output logic                       in_service
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    logic [NUM_SOURCES-1:0]     sync1_q, sync2_q, prev_q;
    logic [NUM_SOURCES-1:0]     pend_q, pend_d;
    logic [NUM_SOURCES-1:0]     mask_q;
    logic [NUM_SOURCES-1:0]     mode_w;
    state_t                     state_q;
    logic [INTERRUPT_WIDTH-1:0] id_q;
    logic                       in_service_q;

    logic [NUM_SOURCES-1:0]     edge_det;
    logic [NUM_SOURCES-1:0]     eligible;
    logic [NUM_SOURCES-1:0]     id_onehot;
    logic [NUM_SOURCES-1:0]     pend_clr;
    logic [INTERRUPT_WIDTH-1:0] win_id;
    logic                       src_eligible;
    logic                       accept;

    // Synchroniser, edge history, pending and mask registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '1;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pend_q  <= pend_d;
            if (cfg_we && cfg_sel == 2'd0) begin
                mask_q <= cfg_wdata;
            end
        end
    end

`ifdef IRQ_LEVEL_SENSE_EN
    logic [NUM_SOURCES-1:0] mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
        end else if (cfg_we && cfg_sel == 2'd2) begin
            mode_q <= cfg_wdata;
        end
    end

    assign mode_w = mode_q;
`else
    assign mode_w = '0;
`endif

    always_comb begin
        edge_det = sync2_q & ~prev_q;
        eligible = pend_q & ~mask_q;

        // Scan downwards so that the lowest eligible index is the last one
        // written, which makes it the winner.
        win_id = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = INTERRUPT_WIDTH'(i + 1);
            end
        end

        // Decode the latched ID back to its source bit (all zeros when ID = 0).
        id_onehot = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (id_q == INTERRUPT_WIDTH'(i + 1)) begin
                id_onehot[i] = 1'b1;
            end
        end

        // The presented source stays valid only while it is still pending and
        // unmasked. This covers a mask write, a PEND clear and a level drop.
        src_eligible = |(eligible & id_onehot);
        accept       = (state_q == S_PRESENT) && src_eligible && ack;

        pend_clr = '0;
        if (accept) begin
            pend_clr = id_onehot;
        end
        if (cfg_we && cfg_sel == 2'd1) begin
            pend_clr = pend_clr | cfg_wdata;
        end

        // Set is OR-ed in after the clear, so a coincident new edge survives.
        pend_d = (pend_q & ~pend_clr) | edge_det;
        // Level-sensitive sources simply track the synchronised line.
        pend_d = (pend_d & ~mode_w) | (sync2_q & mode_w);
    end

    // Presentation FSM with registered ID and in_service outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            id_q         <= '0;
            in_service_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|eligible) begin
                        id_q    <= win_id;
                        state_q <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (!src_eligible) begin
                        id_q    <= '0;
                        state_q <= S_IDLE;
                    end else if (ack) begin
                        in_service_q <= 1'b1;
                        state_q      <= S_SERVICE;
                    end
                end
                S_SERVICE: begin
                    // The ID is held so that the CPU can still read the vector
                    // one cycle after ack.
                    if (eoi) begin
                        in_service_q <= 1'b0;
                        id_q         <= '0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    id_q         <= '0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        case (cfg_sel)
            2'd0:    cfg_rdata = mask_q;
            2'd1:    cfg_rdata = pend_q;
            2'd2:    cfg_rdata = mode_w;
            default: cfg_rdata = '0;
        endcase
    end

    assign interrupt  = id_q;
    assign in_service = in_service_q;

endmodule
